// File: rtl/i2s_target_rx.sv
// -----------------------------------------------------------------------------
// i2s_target_rx
//
// I2S target (slave) receiver. SCK, WS and SD come from an external master and
// are brought into the lmmi_clk_i domain through identical synchronizers, so
// the three stay mutually aligned. Each detected SCK rising edge samples WS and
// SD. Words are MSB first with the standard one-bit WS delay. The edge on which
// WS changes carries the last bit of the slot that is ending.
//
// Ports
//   lmmi_clk_i      system clock, all logic on its rising edge
//   reset           synchronous, active-high reset
//   conf_en_i       receiver enable (0 = idle, outputs hold, synchronizers run)
//   conf_swap_i     0: WS low is left, 1: WS high is left
//   i2s_sck_i       bit clock (asynchronous)
//   i2s_ws_i        word select (asynchronous)
//   i2s_sd_i        serial data (asynchronous)
//   left_o          last complete left sample, left-justified, zero padded
//   right_o         last complete right sample, left-justified, zero padded
//   sample_valid_o  one-cycle pulse when left_o/right_o are updated together
//   frame_err_o     one-cycle pulse when a slot closes with < DATA_WIDTH bits
//   locked_o        receiver aligned and delivering frames
//
// Strobe semantics: there is no back-pressure. sample_valid_o is high for
// exactly one cycle, in the same cycle that left_o/right_o first show the new
// pair. The pair then holds until the next strobe; a consumer that misses the
// strobe may still read the held pair but cannot tell it apart from the old one.
// -----------------------------------------------------------------------------
module i2s_target_rx #(
   parameter int DATA_WIDTH     = 24,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  lmmi_clk_i,
   input  logic                  reset,
   input  logic                  conf_en_i,
   input  logic                  conf_swap_i,
   input  logic                  i2s_sck_i,
   input  logic                  i2s_ws_i,
   input  logic                  i2s_sd_i,
   output logic [DATA_WIDTH-1:0] left_o,
   output logic [DATA_WIDTH-1:0] right_o,
   output logic                  sample_valid_o,
   output logic                  frame_err_o,
   output logic                  locked_o
);

   localparam int CNT_W  = $clog2(DATA_WIDTH + 1);
   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [DATA_WIDTH-1:0] MSB_ONE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   // state_q is the observable FSM state for checkers
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LEFT  = 2'd1,
      ST_RIGHT = 2'd2
   } state_t;

   state_t state_q, state_d;

   // ---------------------------------------------------------------------------
   // Input synchronizers. Not reset: they only carry the external lines, and
   // keeping them running through reset avoids a false SCK edge on release.
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sck_sync, ws_sync, sd_sync;
   logic                   sck_d;

   always_ff @(posedge lmmi_clk_i) begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], i2s_sck_i};
      ws_sync  <= {ws_sync[SYNC_STAGES-2:0],  i2s_ws_i};
      sd_sync  <= {sd_sync[SYNC_STAGES-2:0],  i2s_sd_i};
      sck_d    <= sck_sync[SYNC_STAGES-1];
   end

   logic sck_s, ws_s, sd_s;
   assign sck_s = sck_sync[SYNC_STAGES-1];
   assign ws_s  = ws_sync[SYNC_STAGES-1];
   assign sd_s  = sd_sync[SYNC_STAGES-1];

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic [DATA_WIDTH-1:0] left_q, left_d;
   logic [DATA_WIDTH-1:0] right_q, right_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;
   logic                  ws_prev_q, ws_prev_d;
   logic                  prev_valid_q, prev_valid_d;  // ws_prev_q holds a real sample
   logic                  valid_q, valid_d;
   logic                  err_q, err_d;
   logic                  locked_q, locked_d;

   // ---------------------------------------------------------------------------
   // Edge / channel decode
   // ---------------------------------------------------------------------------
   logic sck_edge, ws_change, left_start, timeout_hit;

   assign sck_edge   = sck_s & ~sck_d;
   assign ws_change  = prev_valid_q & (ws_s ^ ws_prev_q);
   // channel 1 (right) at the previous edge, channel 0 (left) now
   assign left_start = prev_valid_q & (ws_prev_q ^ conf_swap_i) & ~(ws_s ^ conf_swap_i);
   // a detected edge in the same cycle takes priority over the timeout
   assign timeout_hit = ~sck_edge & (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES - 1));

   // Slot contents including this edge's bit; bits past DATA_WIDTH are dropped.
   logic                  can_write;
   logic [DATA_WIDTH-1:0] shift_w;
   logic [CNT_W-1:0]      cnt_w;
   logic                  short_slot;

   always_comb begin
      can_write  = (cnt_q < CNT_W'(DATA_WIDTH));
      shift_w    = shift_q;
      cnt_w      = cnt_q;
      if (can_write) begin
         cnt_w = cnt_q + CNT_W'(1);
         if (sd_s) begin
            shift_w = shift_q | (MSB_ONE >> cnt_q);
         end
      end
      short_slot = (cnt_w < CNT_W'(DATA_WIDTH));
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge lmmi_clk_i) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (!conf_en_i) begin
         state_d = ST_IDLE;
      end else if (sck_edge) begin
         unique case (state_q)
            ST_IDLE:  if (left_start) state_d = ST_LEFT;
            ST_LEFT:  if (ws_change)  state_d = ST_RIGHT;
            ST_RIGHT: if (ws_change)  state_d = ST_LEFT;
            default:  state_d = ST_IDLE;
         endcase
      end else if (timeout_hit) begin
         state_d = ST_IDLE;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs / datapath next values
   // ---------------------------------------------------------------------------
   always_comb begin
      shift_d      = shift_q;
      cnt_d        = cnt_q;
      hold_d       = hold_q;
      left_d       = left_q;
      right_d      = right_q;
      ws_prev_d    = ws_prev_q;
      prev_valid_d = prev_valid_q;
      idle_cnt_d   = idle_cnt_q;
      valid_d      = 1'b0;
      err_d        = 1'b0;
      locked_d     = locked_q;

      if (!conf_en_i) begin
         shift_d      = '0;
         cnt_d        = '0;
         prev_valid_d = 1'b0;
         idle_cnt_d   = '0;
         locked_d     = 1'b0;
      end else if (sck_edge) begin
         ws_prev_d    = ws_s;
         prev_valid_d = 1'b1;
         idle_cnt_d   = '0;
         unique case (state_q)
            ST_LEFT, ST_RIGHT: begin
               if (ws_change) begin
                  // closing edge: its bit belongs to the slot now ending
                  err_d   = short_slot;
                  shift_d = '0;
                  cnt_d   = '0;
                  if (state_q == ST_LEFT) begin
                     hold_d = shift_w;
                  end else begin
                     left_d   = hold_q;
                     right_d  = shift_w;
                     valid_d  = 1'b1;
                     locked_d = 1'b1;
                  end
               end else begin
                  shift_d = shift_w;
                  cnt_d   = cnt_w;
               end
            end
            default: begin
               // idle: data ignored, slot starts clean on a left-start edge
               shift_d = '0;
               cnt_d   = '0;
            end
         endcase
      end else begin
         if (idle_cnt_q != IDLE_W'(TIMEOUT_CYCLES)) begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
         end
         if (timeout_hit) begin
            shift_d      = '0;
            cnt_d        = '0;
            prev_valid_d = 1'b0;
            locked_d     = 1'b0;
         end
      end
   end

   always_ff @(posedge lmmi_clk_i) begin
      if (reset) begin
         shift_q      <= '0;
         cnt_q        <= '0;
         hold_q       <= '0;
         left_q       <= '0;
         right_q      <= '0;
         ws_prev_q    <= 1'b0;
         prev_valid_q <= 1'b0;
         idle_cnt_q   <= '0;
         valid_q      <= 1'b0;
         err_q        <= 1'b0;
         locked_q     <= 1'b0;
      end else begin
         shift_q      <= shift_d;
         cnt_q        <= cnt_d;
         hold_q       <= hold_d;
         left_q       <= left_d;
         right_q      <= right_d;
         ws_prev_q    <= ws_prev_d;
         prev_valid_q <= prev_valid_d;
         idle_cnt_q   <= idle_cnt_d;
         valid_q      <= valid_d;
         err_q        <= err_d;
         locked_q     <= locked_d;
      end
   end

   assign left_o         = left_q;
   assign right_o        = right_q;
   assign sample_valid_o = valid_q;
   assign frame_err_o    = err_q;
   assign locked_o       = locked_q;

endmodule

// File: tb/tb_i2s_target_rx.sv
// -----------------------------------------------------------------------------
// tb_i2s_target_rx
//
// Directed bench for i2s_target_rx with default parameters (24-bit words,
// 2 synchronizer stages, 1024-cycle timeout). SCK runs with 4-cycle low and
// high phases. WS/SD change together with the falling SCK.
// -----------------------------------------------------------------------------
module tb_i2s_target_rx;

   localparam int DW = 24;

   logic          lmmi_clk_i = 1'b0;
   logic          reset      = 1'b1;
   logic          conf_en_i  = 1'b1;
   logic          conf_swap_i = 1'b0;
   logic          i2s_sck_i  = 1'b0;
   logic          i2s_ws_i   = 1'b0;
   logic          i2s_sd_i   = 1'b0;
   logic [DW-1:0] left_o;
   logic [DW-1:0] right_o;
   logic          sample_valid_o;
   logic          frame_err_o;
   logic          locked_o;

   int checks    = 0;
   int errors    = 0;
   int valid_cnt = 0;
   int err_cnt   = 0;

   // WS level carrying the left channel
   logic ws_left = 1'b0;

   // scoreboard: expected {left, right} pairs in delivery order
   logic [2*DW-1:0] exp_q[$];

   i2s_target_rx #(
      .DATA_WIDTH(DW),
      .SYNC_STAGES(2),
      .TIMEOUT_CYCLES(1024)
   ) dut (
      .lmmi_clk_i(lmmi_clk_i),
      .reset(reset),
      .conf_en_i(conf_en_i),
      .conf_swap_i(conf_swap_i),
      .i2s_sck_i(i2s_sck_i),
      .i2s_ws_i(i2s_ws_i),
      .i2s_sd_i(i2s_sd_i),
      .left_o(left_o),
      .right_o(right_o),
      .sample_valid_o(sample_valid_o),
      .frame_err_o(frame_err_o),
      .locked_o(locked_o)
   );

   // ---------------- clock ----------------
   always #5 lmmi_clk_i = ~lmmi_clk_i;

   // ---------------- check ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge lmmi_clk_i) begin
      if (sample_valid_o) begin
         valid_cnt++;
         check("valid_expected", 64'(exp_q.size() != 0), 64'(1));
         if (exp_q.size() != 0) begin
            check("pair", 64'({left_o, right_o}), 64'(exp_q.pop_front()));
         end
      end
      if (frame_err_o) err_cnt++;
   end

   // ---------------- drivers ----------------
   task automatic send_bit(input logic ws, input logic sd);
      @(negedge lmmi_clk_i);
      i2s_sck_i = 1'b0;
      i2s_ws_i  = ws;
      i2s_sd_i  = sd;
      repeat (4) @(negedge lmmi_clk_i);
      i2s_sck_i = 1'b1;
      repeat (3) @(negedge lmmi_clk_i);
   endtask

   // One slot of nbits, MSB first from bits[31]. WS toggles on the last bit.
   task automatic send_slot(input logic ws, input logic [31:0] bits, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         send_bit((i == nbits - 1) ? ~ws : ws, bits[31 - i]);
      end
   endtask

   task automatic send_frame(input logic [31:0] lbits, input logic [31:0] rbits, input int nbits);
      send_slot(ws_left, lbits, nbits);
      send_slot(~ws_left, rbits, nbits);
   endtask

   task automatic settle();
      repeat (6) @(posedge lmmi_clk_i);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] rbits;

      // reset state
      repeat (5) @(posedge lmmi_clk_i);
      #1;
      check("rst_left",   64'(left_o),         64'(0));
      check("rst_right",  64'(right_o),        64'(0));
      check("rst_valid",  64'(sample_valid_o), 64'(0));
      check("rst_err",    64'(frame_err_o),    64'(0));
      check("rst_locked", 64'(locked_o),       64'(0));
      @(negedge lmmi_clk_i);
      reset = 1'b0;

      // normal capture, 32-bit slots, starting mid-frame
      send_slot(1'b0, 32'hA5A5_A5A5, 12);
      send_slot(1'b1, 32'hFFFF_FFFF, 32);
      send_slot(1'b0, {24'h123456, 8'h00}, 32);
      settle();
      check("n_no_early_valid", 64'(valid_cnt), 64'(0));
      check("n_not_locked",     64'(locked_o),  64'(0));
      exp_q.push_back({24'h123456, 24'hABCDEF});
      send_slot(1'b1, {24'hABCDEF, 8'h00}, 32);
      settle();
      check("n_valid_cnt", 64'(valid_cnt), 64'(1));
      check("n_left",      64'(left_o),    64'(24'h123456));
      check("n_right",     64'(right_o),   64'(24'hABCDEF));
      check("n_locked",    64'(locked_o),  64'(1));
      exp_q.push_back({24'h123456, 24'hABCDEF});
      send_frame({24'h123456, 8'h00}, {24'hABCDEF, 8'h00}, 32);
      settle();
      check("n_valid_cnt2", 64'(valid_cnt),    64'(2));
      check("n_no_err",     64'(err_cnt),      64'(0));
      check("n_q_empty",    64'(exp_q.size()), 64'(0));

      // exact-width slots with latency check on the closing edge
      exp_q.push_back({24'h800000, 24'h7FFFFF});
      send_frame({24'h800000, 8'h00}, {24'h7FFFFF, 8'h00}, 24);
      settle();
      check("x_valid_cnt", 64'(valid_cnt), 64'(3));
      check("x_left",      64'(left_o),    64'(24'h800000));
      check("x_right",     64'(right_o),   64'(24'h7FFFFF));
      exp_q.push_back({24'h800000, 24'h7FFFFF});
      send_slot(1'b0, {24'h800000, 8'h00}, 24);
      rbits = {24'h7FFFFF, 8'h00};
      for (int i = 0; i < 23; i++) send_bit(1'b1, rbits[31 - i]);
      @(negedge lmmi_clk_i);
      i2s_sck_i = 1'b0;
      i2s_ws_i  = 1'b0;
      i2s_sd_i  = rbits[8];
      repeat (4) @(negedge lmmi_clk_i);
      i2s_sck_i = 1'b1;
      // two synchronizer stages, then the edge-detect cycle, then the strobe
      repeat (2) @(posedge lmmi_clk_i);
      #1;
      check("x_lat_before", 64'(sample_valid_o), 64'(0));
      @(posedge lmmi_clk_i);
      #1;
      check("x_lat_strobe", 64'(sample_valid_o), 64'(1));
      @(posedge lmmi_clk_i);
      #1;
      check("x_lat_after",  64'(sample_valid_o), 64'(0));
      settle();
      check("x_valid_cnt2", 64'(valid_cnt), 64'(4));
      check("x_no_err",     64'(err_cnt),   64'(0));

      // short 16-bit slots: zero padded, two frame errors per frame
      exp_q.push_back({24'hBEEF00, 24'h123400});
      exp_q.push_back({24'hBEEF00, 24'h123400});
      send_frame({16'hBEEF, 16'h0000}, {16'h1234, 16'h0000}, 16);
      send_frame({16'hBEEF, 16'h0000}, {16'h1234, 16'h0000}, 16);
      settle();
      check("s_valid_cnt", 64'(valid_cnt), 64'(6));
      check("s_err_cnt",   64'(err_cnt),   64'(4));
      check("s_left",      64'(left_o),    64'(24'hBEEF00));
      check("s_right",     64'(right_o),   64'(24'h123400));

      // disable mid-slot, then swap channels
      for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b1);
      @(negedge lmmi_clk_i);
      conf_en_i = 1'b0;
      @(posedge lmmi_clk_i);
      #1;
      check("d_locked",     64'(locked_o), 64'(0));
      check("d_left_hold",  64'(left_o),   64'(24'hBEEF00));
      check("d_right_hold", 64'(right_o),  64'(24'h123400));
      repeat (4) @(negedge lmmi_clk_i);
      conf_swap_i = 1'b1;
      ws_left     = 1'b1;
      conf_en_i   = 1'b1;
      send_slot(1'b0, 32'h3C3C_3C3C, 24);
      exp_q.push_back({24'h111111, 24'h222222});
      send_frame({24'h111111, 8'h00}, {24'h222222, 8'h00}, 24);
      settle();
      check("w_valid_cnt", 64'(valid_cnt), 64'(7));
      check("w_err_cnt",   64'(err_cnt),   64'(4));
      check("w_left",      64'(left_o),    64'(24'h111111));
      check("w_right",     64'(right_o),   64'(24'h222222));

      // timeout: SCK stops mid left slot
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
      repeat (1000) @(negedge lmmi_clk_i);
      check("t_still_locked", 64'(locked_o), 64'(1));
      repeat (60) @(negedge lmmi_clk_i);
      check("t_unlocked",   64'(locked_o),  64'(0));
      check("t_left_hold",  64'(left_o),    64'(24'h111111));
      check("t_right_hold", 64'(right_o),   64'(24'h222222));
      check("t_no_valid",   64'(valid_cnt), 64'(7));
      for (int i = 0; i < 19; i++) send_bit((i == 18) ? 1'b0 : 1'b1, 1'b0);
      send_slot(1'b0, {24'h555555, 8'h00}, 24);
      settle();
      check("t_no_early_valid", 64'(valid_cnt), 64'(7));
      check("t_still_unlocked", 64'(locked_o),  64'(0));
      exp_q.push_back({24'h0A0B0C, 24'hF0F0F0});
      send_frame({24'h0A0B0C, 8'h00}, {24'hF0F0F0, 8'h00}, 24);
      settle();
      check("t_valid_cnt", 64'(valid_cnt), 64'(8));
      check("t_left",      64'(left_o),    64'(24'h0A0B0C));
      check("t_right",     64'(right_o),   64'(24'hF0F0F0));
      check("t_relocked",  64'(locked_o),  64'(1));
      check("t_err_cnt",   64'(err_cnt),   64'(4));

      // reset for one cycle during a right slot
      send_slot(1'b1, {24'h13579B, 8'h00}, 24);
      for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b1);
      @(negedge lmmi_clk_i);
      reset = 1'b1;
      @(posedge lmmi_clk_i);
      #1;
      check("r_left",   64'(left_o),         64'(0));
      check("r_right",  64'(right_o),        64'(0));
      check("r_valid",  64'(sample_valid_o), 64'(0));
      check("r_err",    64'(frame_err_o),    64'(0));
      check("r_locked", 64'(locked_o),       64'(0));
      @(negedge lmmi_clk_i);
      reset = 1'b0;
      for (int i = 6; i < 24; i++) send_bit((i == 23) ? 1'b1 : 1'b0, 1'b0);
      settle();
      check("r_no_early_valid", 64'(valid_cnt), 64'(8));
      exp_q.push_back({24'h2468AC, 24'hFDB975});
      send_frame({24'h2468AC, 8'h00}, {24'hFDB975, 8'h00}, 24);
      settle();
      check("r_valid_cnt", 64'(valid_cnt),    64'(9));
      check("r_left2",     64'(left_o),       64'(24'h2468AC));
      check("r_right2",    64'(right_o),      64'(24'hFDB975));
      check("r_locked2",   64'(locked_o),     64'(1));
      check("r_err_cnt",   64'(err_cnt),      64'(4));
      check("r_q_empty",   64'(exp_q.size()), 64'(0));

      // report
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
